// File: rtl/sdr_word_deserializer_if.sv
// Bus bundle for the SDR word deserializer.
// Pair stream and control in, assembled words and flags out.
interface sdr_word_deserializer_if #(
   parameter int unsigned WIDTH = 10
);
   logic             enable;
   logic [1:0]       data_i;
   logic             bitslip_i;
   logic [WIDTH-1:0] data_o;
   logic             valid_o;
   logic             aligned_o;

   modport master (
      output enable, data_i, bitslip_i,
      input  data_o, valid_o, aligned_o
   );

   modport slave (
      input  enable, data_i, bitslip_i,
      output data_o, valid_o, aligned_o
   );
endinterface

// File: rtl/sdr_word_deserializer.sv
// Assembles the SDR pair stream LSB-first into WIDTH-bit words,
// with single-bit bitslip and a training-pattern alignment flag.
module sdr_word_deserializer #(
   parameter int unsigned      WIDTH   = 10,
   parameter logic [WIDTH-1:0] PATTERN = 10'h17C
) (
   input logic                    clk_i,
   input logic                    reset_n,
   sdr_word_deserializer_if.slave bus
);
   localparam int unsigned NP = WIDTH / 2;
   localparam int unsigned CW = $clog2(NP);
   localparam logic [CW-1:0] LAST = CW'(NP - 1);

   typedef enum logic {
      PH_EVEN = 1'b0,
      PH_ODD  = 1'b1
   } phase_t;

   phase_t           phase_q, phase_d;
   logic             held_q, held_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-3:0] sh_q, sh_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             aligned_q, aligned_d;

   logic [1:0]       pair;
   logic             take;
   logic [WIDTH-1:0] word;

   // Framing state and output registers; reset wins over everything.
   always_ff @(posedge clk_i) begin
      if (!reset_n) begin
         phase_q   <= PH_EVEN;
         held_q    <= 1'b0;
         cnt_q     <= '0;
         sh_q      <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         aligned_q <= 1'b0;
      end else begin
         phase_q   <= phase_d;
         held_q    <= held_d;
         cnt_q     <= cnt_d;
         sh_q      <= sh_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         aligned_q <= aligned_d;
      end
   end

   // Pick the effective pair, apply slips, and fill or emit the word.
   always_comb begin
      phase_d   = phase_q;
      held_d    = held_q;
      cnt_d     = cnt_q;
      sh_d      = sh_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      aligned_d = aligned_q;
      pair      = 2'b00;
      take      = 1'b0;
      word      = '0;
      if (bus.enable) begin
         held_d = bus.data_i[1];
         take   = 1'b1;
         unique case (phase_q)
            PH_EVEN: begin
               pair = bus.data_i;
               if (bus.bitslip_i) begin
                  // Drop this cycle's early bit; the late one is held.
                  phase_d = PH_ODD;
                  take    = 1'b0;
               end
            end
            PH_ODD: begin
               pair = {bus.data_i[0], held_q};
               if (bus.bitslip_i) begin
                  // Drop the held bit and realign to the even pair.
                  phase_d = PH_EVEN;
                  pair    = bus.data_i;
               end
            end
         endcase
         word = {pair, sh_q};
         if (take) begin
            if (cnt_q == LAST) begin
               data_d  = word;
               valid_d = 1'b1;
               cnt_d   = '0;
               if (word == PATTERN) begin
                  aligned_d = 1'b1;
               end
            end else begin
               sh_d  = word[WIDTH-1:2];
               cnt_d = cnt_q + CW'(1);
            end
         end
         if (bus.bitslip_i) begin
            aligned_d = 1'b0;
         end
      end
   end

   assign bus.data_o    = data_q;
   assign bus.valid_o   = valid_q;
   assign bus.aligned_o = aligned_q;
endmodule

// File: tb/tb_sdr_word_deserializer.sv
// Randomized bench for sdr_word_deserializer against a
// bit-queue reference model of the serial stream.
module tb_sdr_word_deserializer;
   localparam int unsigned      W    = 10;
   localparam logic [W-1:0]     PAT  = 10'h2BA;
   localparam logic [W-1:0]     BASE = 10'h2BA;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   sdr_word_deserializer_if #(.WIDTH(W)) bus ();

   sdr_word_deserializer #(
      .WIDTH   (W),
      .PATTERN (PAT)
   ) dut (
      .clk_i   (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   int checks   = 0;
   int failures = 0;

   logic [1:0] P [5] = '{2'b10, 2'b10, 2'b11, 2'b10, 2'b10};
   int pidx = 0;

   bit         bq [$];
   logic [W-1:0] acc;
   int         nacc;
   logic [W-1:0] ed;
   logic       ev;
   logic       ea;

   function automatic logic [W-1:0] rotr(input logic [W-1:0] v,
                                         input int k);
      logic [W-1:0] r;
      r = v;
      for (int i = 0; i < (k % W); i++) begin
         r = {r[0], r[W-1:1]};
      end
      return r;
   endfunction

   // Stream-level model: bits queue up in time order, a slip drops
   // the oldest pending bit, and bits are taken two per cycle.
   task automatic model(input logic rn, input logic en,
                        input logic [1:0] d, input logic sl);
      if (!rn) begin
         bq.delete();
         acc  = '0;
         nacc = 0;
         ed   = '0;
         ev   = 1'b0;
         ea   = 1'b0;
         return;
      end
      ev = 1'b0;
      if (!en) return;
      bq.push_back(d[0]);
      bq.push_back(d[1]);
      if (sl) void'(bq.pop_front());
      if (bq.size() >= 2) begin
         for (int j = 0; j < 2; j++) begin
            acc[nacc] = bq.pop_front();
            nacc++;
         end
         if (nacc == W) begin
            ed   = acc;
            ev   = 1'b1;
            nacc = 0;
            if (acc == PAT) ea = 1'b1;
         end
      end
      if (sl) ea = 1'b0;
   endtask

   task automatic step(input logic rn, input logic en,
                       input logic [1:0] d, input logic sl);
      rst_n         = rn;
      bus.enable    = en;
      bus.data_i    = d;
      bus.bitslip_i = sl;
      @(posedge clk);
      model(rn, en, d, sl);
      #1;
   endtask

   task automatic sstep(input logic sl);
      step(1'b1, 1'b1, P[pidx], sl);
      pidx = (pidx + 1) % 5;
   endtask

   task automatic test_reset;
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b1, 2'b11, 1'b0);
         checks++;
         if (bus.valid_o !== 1'b0 || bus.aligned_o !== 1'b0 ||
             bus.data_o !== '0) begin
            failures++;
            $display("FAIL reset got v=%b a=%b d=%h exp 0 0 000",
                     bus.valid_o, bus.aligned_o, bus.data_o);
         end
      end
      pidx = 0;
   endtask

   task automatic test_basic;
      for (int i = 0; i < 5; i++) begin
         sstep(1'b0);
         checks++;
         if (bus.valid_o !== ev || bus.aligned_o !== ea ||
             bus.data_o !== ed) begin
            failures++;
            $display("FAIL basic_model got %b %b %h exp %b %b %h",
                     bus.valid_o, bus.aligned_o, bus.data_o, ev, ea, ed);
         end
         checks++;
         if (bus.valid_o !== (i == 4)) begin
            failures++;
            $display("FAIL basic_valid i=%0d got %b exp %b",
                     i, bus.valid_o, (i == 4));
         end
      end
      checks++;
      if (bus.data_o !== 10'h2BA) begin
         failures++;
         $display("FAIL basic_word got %h exp 2ba", bus.data_o);
      end
   endtask

   task automatic test_stream;
      for (int i = 0; i < 40; i++) begin
         sstep(1'b0);
         checks++;
         if (bus.valid_o !== ev || bus.aligned_o !== ea ||
             bus.data_o !== ed) begin
            failures++;
            $display("FAIL stream_model got %b %b %h exp %b %b %h",
                     bus.valid_o, bus.aligned_o, bus.data_o, ev, ea, ed);
         end
         checks++;
         if (bus.valid_o !== (i % 5 == 4) ||
             (bus.valid_o && bus.data_o !== 10'h2BA)) begin
            failures++;
            $display("FAIL stream_word i=%0d got v=%b d=%h exp v=%b d=2ba",
                     i, bus.valid_o, bus.data_o, (i % 5 == 4));
         end
      end
   endtask

   task automatic test_bitslip;
      int n;
      int nv;
      int cyc;
      for (int k = 1; k <= 10; k++) begin
         n = $urandom_range(0, 4);
         for (int g = 0; g < n; g++) begin
            sstep(1'b0);
            checks++;
            if (bus.valid_o !== ev || bus.aligned_o !== ea ||
                bus.data_o !== ed) begin
               failures++;
               $display("FAIL slip_model got %b %b %h exp %b %b %h",
                        bus.valid_o, bus.aligned_o, bus.data_o,
                        ev, ea, ed);
            end
         end
         nv = 0;
         cyc = 0;
         sstep(1'b1);
         if (ev) nv++;
         checks++;
         if (bus.valid_o !== ev || bus.aligned_o !== ea ||
             bus.data_o !== ed || bus.aligned_o !== 1'b0) begin
            failures++;
            $display("FAIL slip_edge got %b %b %h exp %b 0 %h",
                     bus.valid_o, bus.aligned_o, bus.data_o, ev, ed);
         end
         while (nv < 2 && cyc < 30) begin
            sstep(1'b0);
            if (ev) nv++;
            cyc++;
            checks++;
            if (bus.valid_o !== ev || bus.aligned_o !== ea ||
                bus.data_o !== ed) begin
               failures++;
               $display("FAIL slip_model got %b %b %h exp %b %b %h",
                        bus.valid_o, bus.aligned_o, bus.data_o,
                        ev, ea, ed);
            end
         end
         checks++;
         if (nv < 2 || bus.data_o !== rotr(BASE, k)) begin
            failures++;
            $display("FAIL slip_word k=%0d got %h exp %h valids=%0d",
                     k, bus.data_o, rotr(BASE, k), nv);
         end
      end
   endtask

   task automatic test_align;
      int nv;
      int cyc;
      step(1'b0, 1'b1, 2'b00, 1'b0);
      pidx = 0;
      for (int k = 1; k <= 11; k++) begin
         nv = 0;
         cyc = 0;
         sstep(1'b1);
         if (ev) nv++;
         checks++;
         if (bus.aligned_o !== 1'b0 || bus.valid_o !== ev ||
             bus.data_o !== ed) begin
            failures++;
            $display("FAIL align_slip k=%0d got a=%b v=%b d=%h exp 0 %b %h",
                     k, bus.aligned_o, bus.valid_o, bus.data_o, ev, ed);
         end
         while (nv < 2 && cyc < 30) begin
            sstep(1'b0);
            if (ev) nv++;
            cyc++;
            checks++;
            if (bus.valid_o !== ev || bus.aligned_o !== ea ||
                bus.data_o !== ed) begin
               failures++;
               $display("FAIL align_model got %b %b %h exp %b %b %h",
                        bus.valid_o, bus.aligned_o, bus.data_o,
                        ev, ea, ed);
            end
         end
         if (k == 1 || k == 10) begin
            checks++;
            if (nv < 2 || bus.aligned_o !== (k == 10) ||
                bus.data_o !== rotr(BASE, k)) begin
               failures++;
               $display("FAIL align_state k=%0d got a=%b d=%h exp a=%b d=%h",
                        k, bus.aligned_o, bus.data_o, (k == 10),
                        rotr(BASE, k));
            end
         end
      end
   endtask

   task automatic test_enable_gap;
      step(1'b0, 1'b1, 2'b11, 1'b0);
      pidx = 0;
      for (int i = 0; i < 11; i++) begin
         if (i >= 2 && i < 5) begin
            step(1'b1, 1'b0, 2'($urandom), 1'($urandom));
         end else begin
            sstep(1'b0);
         end
         checks++;
         if (bus.valid_o !== ev || bus.aligned_o !== ea ||
             bus.data_o !== ed) begin
            failures++;
            $display("FAIL gap_model got %b %b %h exp %b %b %h",
                     bus.valid_o, bus.aligned_o, bus.data_o, ev, ea, ed);
         end
         checks++;
         if (bus.valid_o !== (i == 7) ||
             (i == 7 && bus.data_o !== 10'h2BA)) begin
            failures++;
            $display("FAIL gap_word i=%0d got v=%b d=%h exp v=%b d=2ba",
                     i, bus.valid_o, bus.data_o, (i == 7));
         end
      end
   endtask

   task automatic test_midword_reset;
      step(1'b0, 1'b1, 2'b11, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 2'($urandom), 1'b0);
      end
      step(1'b0, 1'b1, 2'b11, 1'b0);
      pidx = 0;
      for (int i = 0; i < 5; i++) begin
         sstep(1'b0);
         checks++;
         if (bus.valid_o !== ev || bus.aligned_o !== ea ||
             bus.data_o !== ed) begin
            failures++;
            $display("FAIL mrst_model got %b %b %h exp %b %b %h",
                     bus.valid_o, bus.aligned_o, bus.data_o, ev, ea, ed);
         end
         checks++;
         if (bus.valid_o !== (i == 4) ||
             bus.data_o !== ((i == 4) ? 10'h2BA : 10'h000)) begin
            failures++;
            $display("FAIL mrst_word i=%0d got v=%b d=%h exp v=%b",
                     i, bus.valid_o, bus.data_o, (i == 4));
         end
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 1500; i++) begin
         step(($urandom % 40) != 0, ($urandom % 5) != 0,
              2'($urandom), ($urandom % 6) == 0);
         checks++;
         if (bus.valid_o !== ev || bus.aligned_o !== ea ||
             bus.data_o !== ed) begin
            failures++;
            $display("FAIL random i=%0d got %b %b %h exp %b %b %h",
                     i, bus.valid_o, bus.aligned_o, bus.data_o,
                     ev, ea, ed);
         end
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.enable    = 1'b0;
      bus.data_i    = 2'b00;
      bus.bitslip_i = 1'b0;
      acc  = '0;
      nacc = 0;
      ed   = '0;
      ev   = 1'b0;
      ea   = 1'b0;
      test_reset();
      test_basic();
      test_stream();
      test_bitslip();
      test_align();
      test_enable_gap();
      test_midword_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sdr_word_deserializer.md
# sdr_word_deserializer

Downstream stage of the DDR-to-SDR capture block. It consumes the 2-bit SDR pair stream (bit 0 = rising-edge sample, earlier in time; bit 1 = falling-edge sample, later) and assembles it LSB-first into WIDTH-bit parallel words. It provides single-bit word-boundary adjustment (bitslip) and a pattern-match alignment flag, so link training logic can lock word framing.

## Interface
- WIDTH, 10, output word width; even, 4..32.
- PATTERN, 10'h17C, WIDTH-bit training word that sets aligned_o.

- clk_i  in  1  single clock; all logic is rising-edge.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  capture enable; when low, nothing advances.
- data_i  in  2  SDR pair from the DDR-to-SDR stage; [0] is the earlier bit.
- bitslip_i  in  1  each high cycle (while enable is high) shifts the word boundary one bit later in the stream.
- data_o  out  WIDTH  last completed word; bit 0 is the earliest bit.
- valid_o  out  1  one-cycle pulse when data_o is updated.
- aligned_o  out  1  high once an emitted word equals PATTERN.

## Operation
- State:
  - phase register, 0 or 1.
  - held bit: data_i[1] from the previous enabled cycle.
  - pair counter, 0..WIDTH/2-1.
  - WIDTH-2 bit shift register.
- Effective pair each enabled cycle:
  - phase 0: {data_i[1], data_i[0]}.
  - phase 1: {data_i[0], held bit}.
- The pair fills word bits [2k+1:2k], where k = pair counter.
- When k = WIDTH/2-1:
  - data_o <= {pair, shift register}; valid_o <= 1; counter wraps to 0.
  - aligned_o <= 1 if the new word equals PATTERN; otherwise aligned_o keeps its value.
- Bitslip (enable and bitslip_i both high) drops exactly one stream bit:
  - phase 0 -> 1: this cycle's pair is discarded. Counter and shift register hold; held bit is updated.
  - phase 1 -> 0: this cycle's phase-0 pair is used normally. The held bit is never consumed.
  - In both cases aligned_o clears in the same edge.
- Enable low: phase, counter, shift register, held bit, data_o and aligned_o all hold; valid_o = 0; bitslip_i is ignored.
- Reset (reset_n low at an edge) returns to the reset state:
  - data_o = 0, valid_o = 0, aligned_o = 0.
  - phase = 0, counter = 0, shift register = 0, held bit = 0.
  - Any partial word is discarded. The first enabled pair after reset is word bits [1:0].
- Reset has priority over enable and bitslip_i.

## Timing
- Latency: the final pair of a word is sampled at edge N. data_o and valid_o are visible after edge N, i.e. one cycle after that pair is presented.
- Throughput: one word per WIDTH/2 enabled cycles. valid_o is never high on two consecutive cycles when WIDTH >= 4.
- A phase 0->1 slip delays the next valid_o by one enabled cycle. A phase 1->0 slip does not change valid cadence.
- The word in progress at a slip is emitted with its boundary shifted from the slip point. Checkers ignore the first valid_o after a slip.
- Slips on consecutive enabled cycles are each honoured (one bit each).
- Enable deasserted mid-word: assembly resumes at the same k after re-enable, with no bit loss or duplication.

## Test plan
- Reset check: reset_n = 0 for 2 edges with data_i = 2'b11 and enable = 1 -> data_o = 0, valid_o = 0, aligned_o = 0.
- Basic word: WIDTH = 10; after reset, enable = 1 and drive pairs 2'b10, 2'b10, 2'b11, 2'b10, 2'b10.
  - Required: exactly one valid_o pulse, after the 5th edge, with data_o = 10'h2BA.
  - Required: valid_o = 0 on every other cycle.
- Continuous stream: repeat the 0x2BA pair sequence for 8 words -> valid_o every 5th cycle and data_o = 10'h2BA each time.
- Single bitslip: on the repeating 0x2BA stream, pulse bitslip_i for 1 cycle -> from the second valid after the slip, data_o = 10'h15D.
  - A second slip -> data_o = 10'h2AE.
  - Ten total slips -> data_o = 10'h2BA again.
- Alignment: set PATTERN = 10'h2BA and start from a misaligned stream.
  - Required: aligned_o = 0 until slips bring data_o to 10'h2BA; it sets on that valid edge.
  - Required: a further slip clears aligned_o at the slip edge.
- Enable gap and mid-word reset:
  - Drop enable for 3 cycles after pair 2 -> word still 10'h2BA, with valid delayed by 3 cycles.
  - Assert reset after pair 3, then send a full word -> that word is emitted correctly and no stale bits appear.
